arm_shifter_operand: RTL and testbench



---
 rtl/arm_shift_pkg.sv | 25 ++
 rtl/arm_shift_step.sv | 39 +++
 rtl/arm_shifter_operand.sv | 139 +++++++++++++
 tb/tb_arm_shifter_operand.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arm_shift_pkg.sv
// Shared encodings for the iterative ARM shifter-operand generator.
package arm_shift_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_IMM   = 2'b00,
    MODE_SHIMM = 2'b01,
    MODE_SHREG = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shtype_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/arm_shift_step.sv
// One-bit shift/rotate step; carry takes the bit that leaves the word.
module arm_shift_step
  import arm_shift_pkg::*;
(
  input  shtype_e          type_i,
  input  logic [WIDTH-1:0] v_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] v_o,
  output logic             c_o
);

  always_comb begin
    v_o = v_i;
    c_o = c_i;
    case (type_i)
      LSL: begin
        c_o = v_i[WIDTH-1];
        v_o = {v_i[WIDTH-2:0], 1'b0};
      end
      LSR: begin
        c_o = v_i[0];
        v_o = {1'b0, v_i[WIDTH-1:1]};
      end
      ASR: begin
        c_o = v_i[0];
        v_o = {v_i[WIDTH-1], v_i[WIDTH-1:1]};
      end
      ROR: begin
        c_o = v_i[0];
        v_o = {v_i[0], v_i[WIDTH-1:1]};
      end
      default: begin
        v_o = v_i;
        c_o = c_i;
      end
    endcase
  end

endmodule

// File: rtl/arm_shifter_operand.sv
// ARM shifter_operand / shifter_carry_out generator, one bit per clock
// under a start/done handshake. States: IDLE wait, SHIFT stepping, DONE result valid.
module arm_shifter_operand
  import arm_shift_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MODE,
  input  logic [1:0]       SHTYPE,
  input  logic [WIDTH-1:0] RM,
  input  logic [7:0]       RS,
  input  logic [4:0]       SHAMT,
  input  logic [7:0]       IMM8,
  input  logic [3:0]       ROT,
  input  logic             C_IN,
  output logic [WIDTH-1:0] OPERAND,
  output logic             CARRY_OUT,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             c_q, c_d;
  logic [5:0]       cnt_q, cnt_d;
  shtype_e          type_q, type_d;

  logic [WIDTH-1:0] dec_val;
  logic             dec_c;
  logic [5:0]       dec_k;
  logic [WIDTH-1:0] step_v;
  logic             step_c;

  arm_shift_step u_step (
    .type_i (type_q),
    .v_i    (val_q),
    .c_i    (c_q),
    .v_o    (step_v),
    .c_o    (step_c)
  );

  // Fast-path result and step count; dec_c only matters when dec_k is zero.
  always_comb begin
    dec_val = RM;
    dec_c   = C_IN;
    dec_k   = 6'd0;
    case (MODE)
      MODE_IMM: begin
        dec_val = {{(WIDTH-8){1'b0}}, IMM8};
        dec_k   = {1'b0, ROT, 1'b0};
      end
      MODE_SHREG: begin
        if (RS != 8'd0) begin
          case (SHTYPE)
            LSL, LSR: begin
              if (RS > 8'd32) begin
                dec_val = '0;
                dec_c   = 1'b0;
              end else begin
                dec_k = RS[5:0];
              end
            end
            ASR: dec_k = (RS >= 8'd32) ? 6'd32 : RS[5:0];
            default: begin
              if (RS[4:0] == 5'd0) dec_c = RM[WIDTH-1];
              else                 dec_k = {1'b0, RS[4:0]};
            end
          endcase
        end
      end
      default: begin
        case (SHTYPE)
          LSL:      dec_k = {1'b0, SHAMT};
          LSR, ASR: dec_k = (SHAMT == 5'd0) ? 6'd32 : {1'b0, SHAMT};
          default: begin
            if (SHAMT == 5'd0) begin
              dec_val = {C_IN, RM[WIDTH-1:1]};
              dec_c   = RM[0];
            end else begin
              dec_k = {1'b0, SHAMT};
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          val_d   = dec_val;
          c_d     = dec_c;
          cnt_d   = dec_k;
          // Immediate rotates reuse the ROR step regardless of SHTYPE.
          type_d  = (MODE == MODE_IMM) ? ROR : shtype_e'(SHTYPE);
          state_d = (dec_k == 6'd0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        val_d = step_v;
        c_d   = step_c;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= 6'd0;
      type_q  <= LSL;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
    end
  end

  assign OPERAND   = val_q;
  assign CARRY_OUT = c_q;
  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_arm_shifter_operand.sv
// Directed and randomized checks of arm_shifter_operand against an arithmetic ARM shifter model.
module tb_arm_shifter_operand;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  MODE, SHTYPE;
  logic [31:0] RM;
  logic [7:0]  RS;
  logic [4:0]  SHAMT;
  logic [7:0]  IMM8;
  logic [3:0]  ROT;
  logic        C_IN;
  logic [31:0] OPERAND;
  logic        CARRY_OUT, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  arm_shifter_operand dut (
    .clk(clk), .reset(reset), .start(start), .MODE(MODE), .SHTYPE(SHTYPE),
    .RM(RM), .RS(RS), .SHAMT(SHAMT), .IMM8(IMM8), .ROT(ROT), .C_IN(C_IN),
    .OPERAND(OPERAND), .CARRY_OUT(CARRY_OUT), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word shift by n using wide arithmetic: carry is the last bit shifted out.
  function automatic void shift_ref(input logic [1:0] sh, input logic [31:0] rm, input int n,
                                    output logic [31:0] op, output logic c);
    logic [63:0] x;
    case (sh)
      2'd0: begin x = {32'b0, rm} << n;  op = x[31:0];  c = x[32]; end
      2'd1: begin x = {rm, 32'b0} >> n;  op = x[63:32]; c = x[31]; end
      2'd2: begin x = $signed({rm, 32'b0}) >>> n; op = x[63:32]; c = x[31]; end
      default: begin x = {rm, rm} >> n;  op = x[31:0];  c = op[31]; end
    endcase
  endfunction

  function automatic void model(input logic [1:0] m, input logic [1:0] sh, input logic [31:0] rm,
                                input logic [7:0] rs, input logic [4:0] shamt, input logic [7:0] imm,
                                input logic [3:0] rot, input logic cin,
                                output logic [31:0] op, output logic c, output int k);
    int n;
    op = rm; c = cin; k = 0;
    if (m == 2'd0) begin
      op = {24'b0, imm};
      if (rot != 0) begin
        k = 2 * int'(rot);
        shift_ref(2'd3, {24'b0, imm}, k, op, c);
      end
    end else if (m == 2'd2) begin
      n = int'(rs);
      if (n != 0) begin
        if (sh == 2'd3) begin
          if (n % 32 == 0) c = rm[31];
          else begin k = n % 32; shift_ref(sh, rm, k, op, c); end
        end else if (sh == 2'd2) begin
          k = (n > 32) ? 32 : n;
          shift_ref(sh, rm, k, op, c);
        end else if (n > 32) begin
          op = 32'd0; c = 1'b0;
        end else begin
          k = n; shift_ref(sh, rm, k, op, c);
        end
      end
    end else begin
      n = int'(shamt);
      if (sh == 2'd0) begin
        if (n != 0) begin k = n; shift_ref(sh, rm, k, op, c); end
      end else if (sh == 2'd3) begin
        if (n == 0) begin op = {cin, rm[31:1]}; c = rm[0]; end
        else begin k = n; shift_ref(sh, rm, k, op, c); end
      end else begin
        k = (n == 0) ? 32 : n;
        shift_ref(sh, rm, k, op, c);
      end
    end
  endfunction

  task automatic issue(input logic [1:0] m, input logic [1:0] sh, input logic [31:0] rm,
                       input logic [7:0] rs, input logic [4:0] shamt, input logic [7:0] imm,
                       input logic [3:0] rot, input logic cin);
    MODE = m; SHTYPE = sh; RM = rm; RS = rs; SHAMT = shamt; IMM8 = imm; ROT = rot; C_IN = cin;
    start = 1'b1;
  endtask

  task automatic scramble();
    MODE = 2'($urandom_range(0, 3)); SHTYPE = 2'($urandom_range(0, 3));
    RM = $urandom; RS = 8'($urandom_range(0, 255)); SHAMT = 5'($urandom_range(0, 31));
    IMM8 = 8'($urandom_range(0, 255)); ROT = 4'($urandom_range(0, 15)); C_IN = 1'($urandom_range(0, 1));
  endtask

  // Called at the negedge where start was raised; returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input logic [31:0] exp_op, input logic exp_c, input int k);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b0;
    scramble();
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(k + 1));
    check({tag, " busy_cycles"}, 32'(bcnt), 32'(k));
    check({tag, " operand"}, OPERAND, exp_op);
    check({tag, " carry"}, {31'b0, CARRY_OUT}, {31'b0, exp_c});
    check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [1:0]  m, sh;
    logic [31:0] rm, eop, hold_op;
    logic [7:0]  rs, imm;
    logic [4:0]  shamt;
    logic [3:0]  rot;
    logic        cin, ec, hold_c;
    int          k, dseen;

    reset = 1'b1; start = 1'b0;
    MODE = 0; SHTYPE = 0; RM = 0; RS = 0; SHAMT = 0; IMM8 = 0; ROT = 0; C_IN = 0;
    repeat (2) @(negedge clk);
    check("reset operand", OPERAND, 32'd0);
    check("reset carry", {31'b0, CARRY_OUT}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'd0, 2'd0, 32'h0, 8'd0, 5'd0, 8'hFF, 4'd4, 1'b0);
    wait_done("imm_rot", 32'hFF000000, 1'b1, 8);
    @(negedge clk);

    issue(2'd1, 2'd1, 32'h80000001, 8'd0, 5'd0, 8'd0, 4'd0, 1'b0);
    wait_done("lsr32", 32'h0, 1'b1, 32);
    @(negedge clk);

    issue(2'd2, 2'd0, 32'hFFFFFFFF, 8'd40, 5'd0, 8'd0, 4'd0, 1'b1);
    wait_done("lsl_rs40", 32'h0, 1'b0, 0);
    @(negedge clk);

    issue(2'd1, 2'd3, 32'h00000003, 8'd0, 5'd0, 8'd0, 4'd0, 1'b1);
    wait_done("rrx", 32'h80000001, 1'b1, 0);
    @(negedge clk);

    issue(2'd2, 2'd2, 32'h80000010, 8'd4, 5'd0, 8'd0, 4'd0, 1'b0);
    wait_done("asr4", 32'hF8000001, 1'b0, 4);
    issue(2'd2, 2'd0, 32'hFFFFFFFF, 8'd40, 5'd0, 8'd0, 4'd0, 1'b1);
    wait_done("b2b_k0", 32'h0, 1'b0, 0);
    issue(2'd0, 2'd0, 32'h0, 8'd0, 5'd0, 8'hFF, 4'd4, 1'b0);
    wait_done("b2b_k8", 32'hFF000000, 1'b1, 8);
    @(negedge clk);
    check("hold done", {31'b0, done}, 32'd0);
    check("hold operand", OPERAND, 32'hFF000000);

    // Abort a 10-step shift with reset after three steps.
    issue(2'd1, 2'd0, 32'h12345678, 8'd0, 5'd10, 8'd0, 4'd0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort operand", OPERAND, 32'd0);
    check("abort carry", {31'b0, CARRY_OUT}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dseen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    check("abort no_done", 32'(dseen), 32'd0);
    issue(2'd1, 2'd0, 32'h12345678, 8'd0, 5'd10, 8'd0, 4'd0, 1'b0);
    wait_done("after_abort", 32'hD159E000, 1'b0, 10);

    for (int i = 0; i < 150; i++) begin
      m = 2'($urandom_range(0, 3)); sh = 2'($urandom_range(0, 3));
      rm = $urandom; imm = 8'($urandom_range(0, 255)); rot = 4'($urandom_range(0, 15));
      cin = 1'($urandom_range(0, 1));
      shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: rs = 8'($urandom_range(0, 40));
        1: rs = 8'($urandom_range(0, 255));
        2: rs = 8'($urandom_range(31, 33));
        default: rs = {3'($urandom_range(0, 7)), 5'd0};
      endcase
      model(m, sh, rm, rs, shamt, imm, rot, cin, eop, ec, k);
      issue(m, sh, rm, rs, shamt, imm, rot, cin);
      wait_done($sformatf("rand%0d m%0d t%0d", i, m, sh), eop, ec, k);
      if ($urandom_range(0, 1) == 1) begin
        hold_op = OPERAND; hold_c = CARRY_OUT;
        @(negedge clk);
        check("rand hold done", {31'b0, done}, 32'd0);
        check("rand hold operand", OPERAND, eop);
        check("rand hold carry", {31'b0, CARRY_OUT}, {31'b0, ec});
        if (hold_op !== eop || hold_c !== ec) @(negedge clk);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
